// File: rtl/lsu_bus_controller_if.sv
// rtl/lsu_bus_controller_if.sv - ready/ack data bus between the LSU sequencer and memory
interface lsu_bus_controller_if;
  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [3:0]  busBe;
  logic [31:0] busWdata;
  logic        busAck;
  logic [31:0] busRdata;

  modport master (
    output busReq, busWe, busAddr, busBe, busWdata,
    input  busAck, busRdata
  );

  modport slave (
    input  busReq, busWe, busAddr, busBe, busWdata,
    output busAck, busRdata
  );
endinterface

// File: rtl/lsu_bus_controller.sv
// rtl/lsu_bus_controller.sv - multi-cycle load/store sequencer with ack timeout
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses complete without a bus cycle.
module lsu_bus_controller #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_isStore,
  input  logic [2:0]           i_loadSrc,
  input  logic [1:0]           i_storeSrc,
  input  logic [31:0]          i_addr,
  input  logic [31:0]          i_wdata,
  output logic                 o_stall,
  output logic                 o_done,
  output logic [31:0]          o_rdata,
  output logic                 o_timeout,
`ifdef MISALIGN_TRAP_EN
  output logic                 o_misalign,
`endif
  lsu_bus_controller_if.master bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_addr;
  logic [1:0]       r_lane;
  logic [1:0]       r_size;
  logic             r_signed;
  logic             r_store;
  logic [3:0]       r_be;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  logic             r_timeout;
`ifdef MISALIGN_TRAP_EN
  logic             r_misalign;
  logic             w_misalign;
`endif

  logic [1:0]  w_size;
  logic        w_signed;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;
  logic        w_last_cnt;

  // Request decode from the control unit's size codes.
  always_comb begin
    w_size   = SZ_WORD;
    w_signed = 1'b0;
    if (i_isStore) begin
      case (i_storeSrc)
        2'b00:   w_size = SZ_BYTE;
        2'b01:   w_size = SZ_HALF;
        default: w_size = SZ_WORD;
      endcase
    end else begin
      case (i_loadSrc)
        3'b000: begin w_size = SZ_BYTE; w_signed = 1'b1; end
        3'b001: begin w_size = SZ_HALF; w_signed = 1'b1; end
        3'b011: w_size = SZ_BYTE;
        3'b100: w_size = SZ_HALF;
        default: w_size = SZ_WORD;
      endcase
    end

    case (w_size)
      SZ_BYTE: w_be = 4'b0001 << i_addr[1:0];
      SZ_HALF: w_be = i_addr[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase

    case (w_size)
      SZ_BYTE: w_wdata = {4{i_wdata[7:0]}};
      SZ_HALF: w_wdata = {2{i_wdata[15:0]}};
      default: w_wdata = i_wdata;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = ((w_size == SZ_HALF) && i_addr[0]) ||
                      ((w_size == SZ_WORD) && (i_addr[1:0] != 2'b00));
`endif

  // Lane extraction uses the registered request, since busRdata arrives in ACCESS.
  always_comb begin
    case (r_lane)
      2'd0:    w_byte = bus.busRdata[7:0];
      2'd1:    w_byte = bus.busRdata[15:8];
      2'd2:    w_byte = bus.busRdata[23:16];
      default: w_byte = bus.busRdata[31:24];
    endcase
    w_half = r_lane[1] ? bus.busRdata[31:16] : bus.busRdata[15:0];

    case (r_size)
      SZ_BYTE: w_ext = {{24{r_signed & w_byte[7]}}, w_byte};
      SZ_HALF: w_ext = {{16{r_signed & w_half[15]}}, w_half};
      default: w_ext = bus.busRdata;
    endcase
  end

  assign w_last_cnt = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_lane    <= '0;
      r_size    <= SZ_BYTE;
      r_signed  <= 1'b0;
      r_store   <= 1'b0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_timeout <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_addr    <= {i_addr[31:2], 2'b00};
            r_lane    <= i_addr[1:0];
            r_size    <= w_size;
            r_signed  <= w_signed;
            r_store   <= i_isStore;
            r_be      <= w_be;
            r_wdata   <= w_wdata;
            r_rdata   <= '0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
`ifdef MISALIGN_TRAP_EN
            r_misalign <= w_misalign;
            r_state    <= w_misalign ? S_RESP : S_ACCESS;
`else
            r_state   <= S_ACCESS;
`endif
          end
        end
        S_ACCESS: begin
          r_cnt <= r_cnt + 1'b1;
          // An ack on the last counting cycle still completes normally.
          if (bus.busAck) begin
            r_rdata <= r_store ? 32'd0 : w_ext;
            r_state <= S_RESP;
          end else if (w_last_cnt) begin
            r_timeout <= 1'b1;
            r_rdata   <= '0;
            r_state   <= S_RESP;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_stall   = ((r_state == S_IDLE) && i_start) || (r_state == S_ACCESS);
  assign o_done    = (r_state == S_RESP);
  assign o_rdata   = (r_state == S_RESP) ? r_rdata : 32'd0;
  assign o_timeout = (r_state == S_RESP) && r_timeout;
`ifdef MISALIGN_TRAP_EN
  assign o_misalign = (r_state == S_RESP) && r_misalign;
`endif

  assign bus.busReq   = (r_state == S_ACCESS);
  assign bus.busWe    = (r_state == S_ACCESS) && r_store;
  assign bus.busAddr  = r_addr;
  assign bus.busBe    = r_be;
  assign bus.busWdata = r_wdata;

endmodule

// File: tb/tb_lsu_bus_controller.sv
// tb/tb_lsu_bus_controller.sv - randomized self-checking bench for lsu_bus_controller
module tb_lsu_bus_controller;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [2:0]  load_src;
  logic [1:0]  store_src;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        timeout;
`ifdef MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  lsu_bus_controller_if bus();

  always #5 clk = ~clk;

  lsu_bus_controller #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_start    (start),
    .i_isStore  (is_store),
    .i_loadSrc  (load_src),
    .i_storeSrc (store_src),
    .i_addr     (addr),
    .i_wdata    (wdata),
    .o_stall    (stall),
    .o_done     (done),
    .o_rdata    (rdata),
    .o_timeout  (timeout),
`ifdef MISALIGN_TRAP_EN
    .o_misalign (misalign),
`endif
    .bus        (bus)
  );

  // Reference model: access size in bytes, lanes and extension from plain arithmetic.
  function automatic int size_bytes(input bit st, input logic [2:0] ld, input logic [1:0] ss);
    if (st) return (ss == 2'd0) ? 1 : (ss == 2'd1) ? 2 : 4;
    if (ld == 3'd0 || ld == 3'd3) return 1;
    if (ld == 3'd1 || ld == 3'd4) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] model_be(input int n, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    if (n == 1) return 4'(1 << off);
    if (n == 2) return (off >= 2) ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic logic [31:0] model_wdata(input int n, input logic [31:0] d);
    if (n == 1) return (d % 256) * 32'h0101_0101;
    if (n == 2) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_rdata(input int n, input bit sgn, input logic [31:0] a,
                                              input logic [31:0] word);
    logic [31:0] v;
    int off;
    off = int'(a % 4);
    if (n == 1) begin
      v = (word >> (8 * off)) % 256;
      if (sgn && v >= 128) v = v - 32'd256;
    end else if (n == 2) begin
      v = (word >> (16 * (off / 2))) % 65536;
      if (sgn && v >= 32768) v = v - 32'd65536;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic bit model_misaligned(input int n, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    return (n == 2 && (a % 2) != 0) || (n == 4 && (a % 4) != 0);
`else
    return (n == 0) && (a == 32'd0);
`endif
  endfunction

  // One access; ack_dly = non-ack ACCESS cycles before the ack (>= TO means never).
  task automatic run_access(input bit st, input logic [2:0] ld, input logic [1:0] ss,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] word, input int ack_dly, input string tag);
    int n, acc;
    bit sgn, mis, to_exp;
    logic [31:0] exp_rd;
    n      = size_bytes(st, ld, ss);
    sgn    = !st && (ld == 3'd0 || ld == 3'd1);
    mis    = model_misaligned(n, a);
    acc    = mis ? 0 : ((ack_dly < TO) ? ack_dly + 1 : TO);
    to_exp = !mis && (ack_dly >= TO);
    exp_rd = (st || to_exp || mis) ? 32'd0 : model_rdata(n, sgn, a, word);

    @(negedge clk);
    start = 1'b1; is_store = st; load_src = ld; store_src = ss; addr = a; wdata = wd;
    bus.busAck = 1'b0;
    #1;
    n_checks++;
    if ({stall, done, bus.busReq} !== 3'b100) begin
      n_fail++;
      $display("FAIL %s launch: stall/done/req=%b expected 100", tag, {stall, done, bus.busReq});
    end

    for (int k = 1; k <= acc; k++) begin
      @(negedge clk);
      bus.busAck = 1'b0;
      #1;
      n_checks++;
      if ({bus.busReq, stall, done, bus.busWe} !== {3'b110, st}) begin
        n_fail++;
        $display("FAIL %s access[%0d]: req/stall/done/we=%b expected %b",
                 tag, k, {bus.busReq, stall, done, bus.busWe}, {3'b110, st});
      end
      n_checks++;
      if ({bus.busAddr, bus.busBe} !== {a & 32'hFFFF_FFFC, model_be(n, a)}) begin
        n_fail++;
        $display("FAIL %s addr_be[%0d]: got %h/%b expected %h/%b", tag, k,
                 bus.busAddr, bus.busBe, a & 32'hFFFF_FFFC, model_be(n, a));
      end
      if (st) begin
        n_checks++;
        if (bus.busWdata !== model_wdata(n, wd)) begin
          n_fail++;
          $display("FAIL %s wdata[%0d]: got %h expected %h", tag, k, bus.busWdata,
                   model_wdata(n, wd));
        end
      end
      if (k == ack_dly + 1) begin
        bus.busAck = 1'b1; bus.busRdata = word;
      end else begin
        bus.busRdata = $urandom;
      end
    end

    @(negedge clk);
    bus.busAck = 1'b0;
    #1;
    n_checks++;
    if ({done, stall, bus.busReq, timeout} !== {3'b100, to_exp}) begin
      n_fail++;
      $display("FAIL %s resp: done/stall/req/timeout=%b expected %b", tag,
               {done, stall, bus.busReq, timeout}, {3'b100, to_exp});
    end
    n_checks++;
    if (rdata !== exp_rd) begin
      n_fail++;
      $display("FAIL %s rdata: got %h expected %h", tag, rdata, exp_rd);
    end
`ifdef MISALIGN_TRAP_EN
    n_checks++;
    if (misalign !== mis) begin
      n_fail++;
      $display("FAIL %s misalign: got %b expected %b", tag, misalign, mis);
    end
`endif

    @(negedge clk);
    start = 1'b0;
    #1;
    n_checks++;
    if ({done, stall, bus.busReq} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s idle_after: done/stall/req=%b expected 000", tag, {done, stall, bus.busReq});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; is_store = 1'b0; load_src = 3'd0; store_src = 2'd0;
    addr = '0; wdata = '0; bus.busAck = 1'b0; bus.busRdata = '0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({stall, done, rdata, timeout, bus.busReq, bus.busWe, bus.busAddr, bus.busBe,
         bus.busWdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: stall=%b done=%b rdata=%h req=%b addr=%h be=%b wd=%h",
               stall, done, rdata, bus.busReq, bus.busAddr, bus.busBe, bus.busWdata);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    run_access(1'b0, 3'b010, 2'b00, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, "lw_100");
    run_access(1'b0, 3'b000, 2'b00, 32'h203, 32'h0, 32'h8012_3456, 0, "lb_203");
    run_access(1'b0, 3'b011, 2'b00, 32'h203, 32'h0, 32'h8012_3456, 0, "lbu_203");
    run_access(1'b1, 3'b000, 2'b01, 32'h302, 32'h1234_ABCD, 32'h5555_5555, 3, "sh_302");
    run_access(1'b1, 3'b000, 2'b10, 32'h101, 32'hCAFE_F00D, 32'h0, 0, "sw_101");
    run_access(1'b0, 3'b001, 2'b00, 32'h402, 32'h0, 32'h9ABC_1234, 1, "lh_402");
    run_access(1'b0, 3'b100, 2'b00, 32'h402, 32'h0, 32'h9ABC_1234, 2, "lhu_402");
  endtask

  task automatic test_timeout();
    run_access(1'b0, 3'b010, 2'b00, 32'h600, 32'h0, 32'h1111_2222, 1000, "lw_timeout");
    run_access(1'b0, 3'b010, 2'b00, 32'h604, 32'h0, 32'h3333_4444, TO - 1, "lw_ack_last");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.busAck = 1'b1; bus.busRdata = $urandom;
      #1;
      n_checks++;
      if ({bus.busReq, done, stall} !== 3'b000) begin
        n_fail++;
        $display("FAIL idle_ack[%0d]: req/done/stall=%b expected 000", i, {bus.busReq, done, stall});
      end
    end
    @(negedge clk);
    bus.busAck = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; load_src = 3'b010; addr = 32'h500; bus.busAck = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.busReq !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_req: busReq=%b expected 1", bus.busReq);
    end
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
    bus.busAck = 1'b1; bus.busRdata = 32'hFFFF_FFFF;
    #1;
    n_checks++;
    if ({bus.busReq, stall, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_reset: req/stall/done=%b expected 000", {bus.busReq, stall, done});
    end
    reset = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if ({bus.busReq, stall, done, rdata} !== '0) begin
      n_fail++;
      $display("FAIL late_ack: req/stall/done=%b rdata=%h expected 0", {bus.busReq, stall, done}, rdata);
    end
    run_access(1'b0, 3'b010, 2'b00, 32'h700, 32'h0, 32'h0BAD_F00D, 0, "lw_after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      bit          st;
      logic [2:0]  ld;
      logic [1:0]  ss;
      int          dly;
      st  = 1'($urandom_range(0, 1));
      ld  = 3'($urandom_range(0, 7));
      ss  = 2'($urandom_range(0, 3));
      dly = ($urandom_range(0, 7) == 0) ? (TO - 1 + $urandom_range(0, 2)) : $urandom_range(0, 5);
      run_access(st, ld, ss, $urandom, $urandom, $urandom, dly, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
